// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan-code decoder: folds E0/F0/E1 prefixes into {ext, rel, code} key events
// and queues them in a first-word-fall-through event FIFO with a sticky overflow flag.
//
// state  | meaning
// IDLE   | waiting for the first byte of a sequence
// EXT    | E0 seen, next byte is an extended make code (or F0)
// BRK    | F0 seen, next byte is a released key code
// EXTBRK | E0 F0 seen, next byte is an extended released key code
// SKIP   | inside the 8-byte Pause sequence, swallowing bytes
module ps2_scancode_decoder #(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 2_000_000,
  parameter int TW      = 21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_byte,
  input  logic       ev_rd,
  output logic [9:0] ev_data,
  output logic       ev_empty,
  output logic       ev_full,
  output logic       ev_ovf
);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXTBRK, SKIP} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [2:0]      skip_q, skip_d;
  logic [9:0]      mem_q [DEPTH];
  logic [9:0]      mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            ovf_q, ovf_d;

  logic            push, is_prefix, fifo_full, fifo_empty, wr_en, rd_en;
  logic [9:0]      push_data;

  assign is_prefix = (rx_byte == 8'hE0) || (rx_byte == 8'hF0) || (rx_byte == 8'hE1);

  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    tmo_d     = '0;
    push      = 1'b0;
    push_data = '0;
    if (state_q != IDLE) tmo_d = rx_done_tick ? '0 : tmo_q + TW'(1);
    if (rx_done_tick) begin
      unique case (state_q)
        IDLE: begin
          unique case (rx_byte)
            8'hE0: state_d = EXT;
            8'hF0: state_d = BRK;
            8'hE1: begin
              state_d = SKIP;
              skip_d  = 3'd7;
            end
            8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE: state_d = IDLE;
            default: begin
              push      = 1'b1;
              push_data = {2'b00, rx_byte};
            end
          endcase
        end
        EXT: begin
          if (rx_byte == 8'hF0) begin
            state_d = EXTBRK;
          end else begin
            state_d   = IDLE;
            push      = !is_prefix;
            push_data = {2'b10, rx_byte};
          end
        end
        BRK: begin
          state_d   = IDLE;
          push      = !is_prefix;
          push_data = {2'b01, rx_byte};
        end
        EXTBRK: begin
          state_d   = IDLE;
          push      = !is_prefix;
          push_data = {2'b11, rx_byte};
        end
        SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_q == TW'(TIMEOUT - 1)) begin
      // A prefix with no follow-up byte is abandoned so a lost byte cannot taint later events.
      state_d = IDLE;
      tmo_d   = '0;
    end
  end

  assign fifo_full  = (count_q == (AW+1)'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign rd_en      = ev_rd && !fifo_empty;
  assign wr_en      = push && (!fifo_full || rd_en);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q || (push && fifo_full && !rd_en);
    if (wr_en) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      tmo_q    <= '0;
      skip_q   <= '0;
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      skip_q   <= skip_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ev_data  = mem_q[rd_ptr_q];
  assign ev_empty = fifo_empty;
  assign ev_full  = fifo_full;
  assign ev_ovf   = ovf_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: directed scan-code cases plus randomized byte streams,
// checked every cycle against a prefix-list / event-queue model of the decoder.
module tb_ps2_scancode_decoder;

  localparam int DEPTH   = 8;
  localparam int AW      = 3;
  localparam int TIMEOUT = 40;
  localparam int TW      = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       ev_rd = 1'b0;
  logic [9:0] ev_data;
  logic       ev_empty, ev_full, ev_ovf;

  int checks = 0;
  int failures = 0;
  int rd_pct = 0;

  ps2_scancode_decoder #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_byte(rx_byte),
    .ev_rd(ev_rd), .ev_data(ev_data), .ev_empty(ev_empty), .ev_full(ev_full), .ev_ovf(ev_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the current prefix sequence is kept as a list of bytes.
  logic [7:0] seq[$];
  logic [9:0] mq[$];
  logic       m_ovf = 1'b0;
  int         idle_edges = 0;

  function automatic logic is_pfx(input logic [7:0] b);
    return b == 8'hE0 || b == 8'hF0 || b == 8'hE1;
  endfunction

  task automatic decode(input logic [7:0] b, output logic have, output logic [9:0] ev);
    logic e, r;
    have = 1'b0;
    ev   = '0;
    if (seq.size() == 0) begin
      if (is_pfx(b)) seq.push_back(b);
      else if (!(b == 8'h00 || b == 8'hFF || b == 8'hAA || b == 8'hFA || b == 8'hFE)) begin
        have = 1'b1;
        ev   = {2'b00, b};
      end
    end else if (seq[0] == 8'hE1) begin
      seq.push_back(b);
      if (seq.size() == 8) seq.delete();
    end else if (b == 8'hF0 && seq.size() == 1 && seq[0] == 8'hE0) begin
      seq.push_back(b);
    end else begin
      e = 1'b0;
      r = 1'b0;
      foreach (seq[k]) begin
        if (seq[k] == 8'hE0) e = 1'b1;
        if (seq[k] == 8'hF0) r = 1'b1;
      end
      if (!is_pfx(b)) begin
        have = 1'b1;
        ev   = {e, r, b};
      end
      seq.delete();
    end
  endtask

  always @(posedge clk) begin
    logic       pop, have;
    logic [9:0] ev;
    if (reset) begin
      seq.delete();
      mq.delete();
      m_ovf      = 1'b0;
      idle_edges = 0;
    end else begin
      pop  = ev_rd && mq.size() > 0;
      have = 1'b0;
      ev   = '0;
      if (rx_done_tick) begin
        idle_edges = 0;
        decode(rx_byte, have, ev);
      end else if (seq.size() > 0) begin
        idle_edges++;
        if (idle_edges >= TIMEOUT) begin
          seq.delete();
          idle_edges = 0;
        end
      end
      if (have && mq.size() == DEPTH && !pop) m_ovf = 1'b1;
      if (pop) void'(mq.pop_front());
      if (have && mq.size() < DEPTH) mq.push_back(ev);
    end
    #1;
    chk("ev_empty", 32'(ev_empty), 32'(mq.size() == 0));
    chk("ev_full", 32'(ev_full), 32'(mq.size() == DEPTH));
    chk("ev_ovf", 32'(ev_ovf), 32'(m_ovf));
    if (mq.size() > 0) chk("ev_data", 32'(ev_data), 32'(mq[0]));
  end

  task automatic step(input logic tk, input logic [7:0] b, input logic rd);
    @(negedge clk);
    rx_done_tick = tk;
    rx_byte      = b;
    ev_rd        = rd;
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0);
    step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    rx_done_tick = 1'b0;
    ev_rd = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pop_expect(input string nm, input logic [9:0] exp);
    chk({nm, "_nonempty"}, 32'(ev_empty), 32'd0);
    chk(nm, 32'(ev_data), 32'(exp));
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
  endtask

  function automatic logic rnd_rd();
    return $urandom_range(99) < rd_pct;
  endfunction

  initial begin
    logic [7:0] b;
    int         r, g;
    logic [7:0] disc[5];
    disc = '{8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE};

    pulse_reset();
    chk("rst_empty", 32'(ev_empty), 32'd1);
    chk("rst_full", 32'(ev_full), 32'd0);
    chk("rst_ovf", 32'(ev_ovf), 32'd0);
    chk("rst_data", 32'(ev_data), 32'h000);

    send(8'h1C);
    chk("t1_empty_after_tick", 32'(ev_empty), 32'd0);
    pop_expect("t1_make", 10'h01C);

    send(8'hF0); send(8'h1C);
    send(8'hE0); send(8'hF0); send(8'h74);
    send(8'hE0); send(8'h75);
    pop_expect("t2_break", 10'h11C);
    pop_expect("t2_extbreak", 10'h374);
    pop_expect("t2_ext", 10'h275);

    step(1'b1, 8'hE0, 1'b0);
    repeat (TIMEOUT) step(1'b0, 8'h00, 1'b0);
    send(8'h1C);
    pop_expect("t3_timeout", 10'h01C);
    send(8'hAA); send(8'hFA);
    chk("t3_discard_empty", 32'(ev_empty), 32'd1);

    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    chk("t4_pause_empty", 32'(ev_empty), 32'd1);
    send(8'h1C);
    pop_expect("t4_after_pause", 10'h01C);

    for (int i = 0; i <= DEPTH; i++) send(8'h15 + 8'(i));
    chk("t5_full", 32'(ev_full), 32'd1);
    chk("t5_ovf", 32'(ev_ovf), 32'd1);
    for (int i = 0; i < DEPTH; i++) pop_expect("t5_drain", {2'b00, 8'h15 + 8'(i)});
    chk("t5_drained_empty", 32'(ev_empty), 32'd1);

    pulse_reset();
    chk("t6_ovf_cleared", 32'(ev_ovf), 32'd0);
    for (int i = 0; i < DEPTH; i++) send(8'h21 + 8'(i));
    step(1'b1, 8'h33, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("t6_ovf_rdwr", 32'(ev_ovf), 32'd0);
    chk("t6_full_rdwr", 32'(ev_full), 32'd1);
    chk("t6_head_rdwr", 32'(ev_data), 32'h022);
    pulse_reset();
    send(8'hE0);
    pulse_reset();
    send(8'h6B);
    pop_expect("t6_reset_midseq", 10'h06B);

    for (int i = 0; i < 2500; i++) begin
      rd_pct = ((i / 250) % 3 == 0) ? 10 : (((i / 250) % 3 == 1) ? 50 : 90);
      r = $urandom_range(99);
      if (r < 12) b = 8'hE0;
      else if (r < 22) b = 8'hF0;
      else if (r < 26) b = 8'hE1;
      else if (r < 34) b = disc[$urandom_range(4)];
      else b = 8'($urandom_range(255));
      step(1'b1, b, rnd_rd());
      g = ($urandom_range(99) < 5) ? TIMEOUT - 2 + $urandom_range(3) : $urandom_range(3);
      repeat (g) step(1'b0, 8'($urandom_range(255)), rnd_rd());
      if ($urandom_range(299) == 0) pulse_reset();
    end
    repeat (DEPTH + 2) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("final_empty", 32'(ev_empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
